cnt_sched: RTL and testbench

//  Round-robin scheduler sharing one free-running-style up-counter between N requesters.

---
 rtl/cnt_sched_if.sv | 35 +++
 rtl/cnt_sched.sv | 147 ++++++++++++++
 tb/tb_cnt_sched.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_sched_if.sv
// cnt_sched_if: bundles the requester-side signals of the shared-counter scheduler.
//   master : client side (drives req, tc_in, pause; observes grant/done/cnt/cur_id/busy)
//   slave  : scheduler side (the cnt_sched block)
//   req     per-requester level request
//   tc_in   packed terminal counts, requester i at [i*CNT_W +: CNT_W]
//   pause   global hold of the running window
//   grant   one-hot owner of the counter, zero when idle
//   done    one-cycle completion pulse to the owner
//   cnt     shared counter value
//   cur_id  index of the current owner
//   busy    high while a window is running or completing
interface cnt_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 10,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] tc_in;
  logic                   pause;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic [CNT_W-1:0]       cnt;
  logic [ID_W-1:0]        cur_id;
  logic                   busy;

  modport master (
    output req, tc_in, pause,
    input  grant, done, cnt, cur_id, busy
  );

  modport slave (
    input  req, tc_in, pause,
    output grant, done, cnt, cur_id, busy
  );
endinterface

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler sharing one up-counter between N_REQ requesters.
// A granted requester gets the counter for cnt = 0..tc, then a one-cycle done pulse,
// then the block returns to IDLE and re-arbitrates starting after the last owner.
//   sclk   system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cnt_sched_if.slave: req/tc_in/pause in, grant/done/cnt/cur_id/busy out
module cnt_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 10,
  parameter int ID_W  = 2
) (
  input  logic         sclk,
  input  logic         rst_n,
  cnt_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] REQ_ZERO = {N_REQ{1'b0}};
  localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};

  state_t           state_r;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] tc_lat_r;
  logic [ID_W-1:0]  cur_id_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic             busy_r;

  logic             found_s;
  logic [ID_W-1:0]  winner_s;
  logic [ID_W-1:0]  idx_s;
  logic [CNT_W-1:0] tc_arr_s [N_REQ];

  // Pointer advance with wrap at N_REQ (N_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) begin
      next_id = ID_ZERO;
    end else begin
      next_id = id + ID_W'(1);
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_tc
    assign tc_arr_s[i] = bus.tc_in[i*CNT_W +: CNT_W];
  end

  // Round-robin search: first set req at or after rr_ptr_r, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = ID_ZERO;
    idx_s    = ID_ZERO;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
      if (!found_s && bus.req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Scheduler FSM; every output comes straight from a register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= REQ_ZERO;
      done_r   <= REQ_ZERO;
      cnt_r    <= CNT_ZERO;
      tc_lat_r <= CNT_ZERO;
      cur_id_r <= ID_ZERO;
      rr_ptr_r <= ID_ZERO;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= REQ_ZERO;
          if (found_s) begin
            // tc is captured only here; later tc_in changes do not affect this window
            tc_lat_r <= tc_arr_s[winner_s];
            grant_r  <= onehot(winner_s);
            cur_id_r <= winner_s;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            grant_r  <= REQ_ZERO;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          // Abandon outranks both pause and the terminal-count compare.
          if (!bus.req[cur_id_r]) begin
            grant_r  <= REQ_ZERO;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            rr_ptr_r <= next_id(cur_id_r);
            state_r  <= ST_IDLE;
          end else if (bus.pause) begin
            cnt_r    <= cnt_r;
          end else if (cnt_r == tc_lat_r) begin
            // Compare before increment, so cnt never wraps even at tc = max.
            done_r   <= grant_r;
            state_r  <= ST_DONE;
          end else begin
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          grant_r  <= REQ_ZERO;
          done_r   <= REQ_ZERO;
          cnt_r    <= CNT_ZERO;
          busy_r   <= 1'b0;
          rr_ptr_r <= next_id(cur_id_r);
          state_r  <= ST_IDLE;
        end
        default: begin
          grant_r  <= REQ_ZERO;
          done_r   <= REQ_ZERO;
          cnt_r    <= CNT_ZERO;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant  = grant_r;
  assign bus.done   = done_r;
  assign bus.cnt    = cnt_r;
  assign bus.cur_id = cur_id_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: scoreboard bench for cnt_sched. Each scenario pushes the expected
// per-cycle outputs into exp_q while setting up stimulus, then pops one entry per
// falling edge and compares it against the DUT.
module tb_cnt_sched;

  localparam int N_REQ = 4;
  localparam int CNT_W = 10;
  localparam int ID_W  = 2;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] done;
    logic [9:0] cnt;
    logic       busy;
    logic [1:0] id;
  } exp_t;

  logic sclk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e;

  cnt_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  cnt_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic push_cyc(input logic [3:0] g, input logic [3:0] d, input logic [9:0] c,
                          input logic b, input logic [1:0] id);
    exp_t x;
    x.grant = g; x.done = d; x.cnt = c; x.busy = b; x.id = id;
    exp_q.push_back(x);
  endtask

  // Expected window: tc+1 RUN cycles (plus pause_len holds at cnt==pause_at), DONE, IDLE.
  task automatic push_window(input int id, input int tc, input int pause_at, input int pause_len);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    for (int c = 0; c <= tc; c++) begin
      push_cyc(oh, 4'b0000, 10'(c), 1'b1, 2'(id));
      if (c == pause_at) begin
        for (int p = 0; p < pause_len; p++) push_cyc(oh, 4'b0000, 10'(c), 1'b1, 2'(id));
      end
    end
    push_cyc(oh, oh, 10'(tc), 1'b1, 2'(id));
    push_cyc(4'b0000, 4'b0000, 10'd0, 1'b0, 2'd0);
  endtask

  task automatic apply_reset();
    bus.req   = 4'b0000;
    bus.pause = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge sclk);
    rst_n     = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.req   = 4'b0000;
    bus.pause = 1'b0;
    bus.tc_in = '0;
    rst_n     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sclk);
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== 19'd0) begin
        failures++;
        $display("FAIL reset cyc=%0d got g=%b d=%b c=%0d b=%b exp all zero",
                 k, bus.grant, bus.done, bus.cnt, bus.busy);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int k;
    apply_reset();
    bus.tc_in = {10'd0, 10'd0, 10'd0, 10'd5};
    bus.req   = 4'b0001;
    push_window(0, 5, -1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL single cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (e.busy) begin
        checks++;
        if (bus.cur_id !== e.id) begin
          failures++;
          $display("FAIL single_id cyc=%0d got %0d exp %0d", k, bus.cur_id, e.id);
        end
      end
      if (k == 1) bus.tc_in = {10'd0, 10'd0, 10'd0, 10'd2};
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    int k;
    apply_reset();
    bus.tc_in = {10'd2, 10'd2, 10'd2, 10'd2};
    bus.req   = 4'b1111;
    push_window(0, 2, -1, 0);
    push_window(1, 2, -1, 0);
    push_window(2, 2, -1, 0);
    push_window(3, 2, -1, 0);
    push_window(0, 2, -1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL rr cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (e.busy) begin
        checks++;
        if (bus.cur_id !== e.id) begin
          failures++;
          $display("FAIL rr_id cyc=%0d got %0d exp %0d", k, bus.cur_id, e.id);
        end
      end
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_pause();
    int k;
    apply_reset();
    bus.tc_in = {10'd0, 10'd10, 10'd0, 10'd0};
    bus.req   = 4'b0100;
    push_window(2, 10, 3, 4);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL pause cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (k == 4) bus.pause = 1'b1;
      if (k == 8) bus.pause = 1'b0;
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_abandon();
    int k;
    apply_reset();
    bus.tc_in = {10'd0, 10'd1, 10'd20, 10'd0};
    bus.req   = 4'b0110;
    for (int c = 0; c <= 7; c++) push_cyc(4'b0010, 4'b0000, 10'(c), 1'b1, 2'd1);
    push_cyc(4'b0000, 4'b0000, 10'd0, 1'b0, 2'd0);
    push_window(2, 1, -1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL abandon cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (e.busy) begin
        checks++;
        if (bus.cur_id !== e.id) begin
          failures++;
          $display("FAIL abandon_id cyc=%0d got %0d exp %0d", k, bus.cur_id, e.id);
        end
      end
      if (k == 8) bus.req = 4'b0100;
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_tc_corners();
    int k;
    apply_reset();
    bus.tc_in = {10'd0, 10'd0, 10'd0, 10'd0};
    bus.req   = 4'b1000;
    push_window(3, 0, -1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL tc0 cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
    apply_reset();
    bus.tc_in = {10'd0, 10'd0, 10'd0, 10'd1023};
    bus.req   = 4'b0001;
    push_window(0, 1023, -1, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge sclk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({bus.grant, bus.done, bus.cnt, bus.busy} !== {e.grant, e.done, e.cnt, e.busy}) begin
        failures++;
        $display("FAIL tcmax cyc=%0d got g=%b d=%b c=%0d b=%b exp g=%b d=%b c=%0d b=%b",
                 k, bus.grant, bus.done, bus.cnt, bus.busy, e.grant, e.done, e.cnt, e.busy);
      end
      if (exp_q.size() == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.tc_in = {10'd0, 10'd0, 10'd0, 10'd1023};
    bus.req   = 4'b0001;
    repeat (501) @(negedge sclk);
    checks++;
    if (bus.cnt !== 10'd500 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got c=%0d b=%b exp c=500 b=1", bus.cnt, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.done, bus.cnt, bus.busy, bus.cur_id} !== 21'd0) begin
      failures++;
      $display("FAIL mid_reset got g=%b d=%b c=%0d b=%b id=%0d exp all zero",
               bus.grant, bus.done, bus.cnt, bus.busy, bus.cur_id);
    end
    bus.req = 4'b0000;
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    checks++;
    if ({bus.grant, bus.done, bus.cnt, bus.busy} !== 19'd0) begin
      failures++;
      $display("FAIL mid_after got g=%b d=%b c=%0d b=%b exp all zero",
               bus.grant, bus.done, bus.cnt, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pause();
    test_abandon();
    test_tc_corners();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
